// File: rtl/conv_pkg.sv
// conv_pkg
//   Shared definitions for the pointwise convolution engine: FSM state
//   encoding, bank address widths and a constant-foldable ceil(log2) helper.
package conv_pkg;

  localparam int PADDR_W = 16;  // param (weight) bank address width
  localparam int FADDR_W = 15;  // feature-map bank address width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_acc.sv
// mac_acc
//   Signed 8x8 multiply-accumulate. On an enabled cycle the accumulator loads
//   either the bare product (clr=1, first term of a new output) or the running
//   sum plus the product.
//   Ports:
//     clk, rstn   clock, synchronous active-low reset
//     clr         start a new sum with this cycle's product
//     en          accumulate this cycle's product
//     a, b        signed 8-bit operands
//     acc_next    value the accumulator takes at the coming edge when en=1;
//                 lets the parent capture the finished sum without an extra
//                 pipeline cycle
module mac_acc
  import conv_pkg::*;
#(
  parameter int ACC_W = 22
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [7:0]       a,
  input  logic signed [7:0]       b,
  output logic signed [ACC_W-1:0] acc_next
);

  logic signed [15:0]      prod_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] acc_r;

  // Product and candidate accumulator value for this cycle.
  always_comb begin
    prod_s = 16'(a) * 16'(b);
    if (clr) begin
      sum_s = ACC_W'(prod_s);
    end else begin
      sum_s = acc_r + ACC_W'(prod_s);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= sum_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc_next = sum_s;

endmodule

// File: rtl/conv_pw_engine.sv
// conv_pw_engine
//   1x1 (pointwise) convolution over a FMAP_SIZE x FMAP_SIZE map:
//   out[oc][p] = requant(sum_ic W[oc][ic] * X[ic][p]), p inner loop, oc outer.
//   Each output: RUN (CIN read pairs) -> DRAIN (MEM_LAT cycles) -> WRITE (1).
//   If init is high in cycle 0, done is high in cycle COUT*HW*(CIN+MEM_LAT+1)+1.
//   Ports:
//     clk, rstn                 clock, synchronous active-low reset
//     init / busy / done        start level, layer active, completion pulse
//     pbank_addr/pbank_en/pdata weight read port (data MEM_LAT cycles later)
//     fbank_raddr/fbank_ren/fdata_r  feature read port (same latency)
//     fbank_waddr/fdata_w/fbank_wen  result write port
module conv_pw_engine
  import conv_pkg::*;
#(
  parameter int          FMAP_SIZE = 7,
  parameter int          CIN       = 64,
  parameter int          COUT      = 64,
  parameter int          MEM_LAT   = 2,
  parameter logic [15:0] W_BASE    = 16'h1480,
  parameter logic [14:0] IN_BASE   = 15'h4000,
  parameter logic [14:0] OUT_BASE  = 15'h0000,
  parameter int          SHIFT     = 7,
  parameter int          RELU      = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               init,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pbank_addr,
  output logic               pbank_en,
  input  logic signed [7:0]  pdata,
  output logic [14:0]        fbank_raddr,
  output logic               fbank_ren,
  input  logic signed [7:0]  fdata_r,
  output logic [14:0]        fbank_waddr,
  output logic signed [7:0]  fdata_w,
  output logic               fbank_wen
);

  localparam int HW    = FMAP_SIZE * FMAP_SIZE;
  localparam int ACC_W = 16 + clog2(CIN);
  localparam int CNT_W = 16;

  state_e                  state_r, state_s;
  logic [CNT_W-1:0]        ic_r, ic_s;     // index of the next read to issue
  logic [CNT_W-1:0]        p_r, p_s;
  logic [CNT_W-1:0]        oc_r, oc_s;
  logic [2:0]              dcnt_r, dcnt_s;
  logic                    rd_en_r, rd_en_s;
  logic                    first_r, first_s; // read carries ic=0
  logic                    wen_r, wen_s;
  logic                    done_r, done_s;
  logic                    busy_r, busy_s;
  logic [PADDR_W-1:0]      paddr_r, paddr_s;
  logic [FADDR_W-1:0]      raddr_r, raddr_s;
  logic [FADDR_W-1:0]      waddr_r, waddr_s;
  logic signed [7:0]       wdata_r, wdata_s;
  logic [MEM_LAT-1:0]      vld_r;
  logic [MEM_LAT-1:0]      frst_r;
  logic                    last_s;
  logic signed [ACC_W-1:0] acc_next_s;

  function automatic logic [PADDR_W-1:0] w_addr(input logic [CNT_W-1:0] oc,
                                                input logic [CNT_W-1:0] ic);
    return PADDR_W'(32'(W_BASE) + 32'(oc) * 32'(CIN) + 32'(ic));
  endfunction

  function automatic logic [FADDR_W-1:0] x_addr(input logic [CNT_W-1:0] ic,
                                                input logic [CNT_W-1:0] p);
    return FADDR_W'(32'(IN_BASE) + 32'(ic) * 32'(HW) + 32'(p));
  endfunction

  function automatic logic [FADDR_W-1:0] o_addr(input logic [CNT_W-1:0] oc,
                                                input logic [CNT_W-1:0] p);
    return FADDR_W'(32'(OUT_BASE) + 32'(oc) * 32'(HW) + 32'(p));
  endfunction

  // Floor shift, optional ReLU, then saturate into int8.
  function automatic logic signed [7:0] requant(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if ((RELU != 0) && (s < ACC_W'(32'sd0))) begin
      s = '0;
    end else begin
      s = s;
    end
    if (s > ACC_W'(32'sd127)) begin
      return 8'sh7f;
    end else if (s < ACC_W'(-32'sd128)) begin
      return 8'sh80;
    end else begin
      return s[7:0];
    end
  endfunction

  mac_acc #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (frst_r[MEM_LAT-1]),
    .en       (vld_r[MEM_LAT-1]),
    .a        (pdata),
    .b        (fdata_r),
    .acc_next (acc_next_s)
  );

  // Next state, loop counters and the values of every registered output.
  always_comb begin
    state_s = state_r;
    ic_s    = ic_r;
    p_s     = p_r;
    oc_s    = oc_r;
    dcnt_s  = dcnt_r;
    rd_en_s = 1'b0;
    first_s = 1'b0;
    wen_s   = 1'b0;
    done_s  = 1'b0;
    paddr_s = paddr_r;
    raddr_s = raddr_r;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    last_s  = (oc_r == CNT_W'(COUT - 1)) && (p_r == CNT_W'(HW - 1));
    case (state_r)
      IDLE: begin
        if (init) begin
          state_s = RUN;
          rd_en_s = 1'b1;
          first_s = 1'b1;
          ic_s    = 16'd1;
          paddr_s = w_addr(oc_r, 16'd0);
          raddr_s = x_addr(16'd0, p_r);
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (ic_r == CNT_W'(CIN)) begin
          state_s = DRAIN;
          dcnt_s  = 3'd0;
        end else begin
          rd_en_s = 1'b1;
          ic_s    = ic_r + 16'd1;
          paddr_s = w_addr(oc_r, ic_r);
          raddr_s = x_addr(ic_r, p_r);
        end
      end
      DRAIN: begin
        // The last product is being accumulated this cycle, so acc_next
        // already holds the finished sum.
        if (dcnt_r == 3'(MEM_LAT - 1)) begin
          state_s = WRITE;
          wen_s   = 1'b1;
          waddr_s = o_addr(oc_r, p_r);
          wdata_s = requant(acc_next_s);
        end else begin
          dcnt_s = dcnt_r + 3'd1;
        end
      end
      WRITE: begin
        if (last_s) begin
          state_s = FIN;
          done_s  = 1'b1;
          oc_s    = 16'd0;
          p_s     = 16'd0;
          ic_s    = 16'd0;
        end else begin
          if (p_r == CNT_W'(HW - 1)) begin
            p_s  = 16'd0;
            oc_s = oc_r + 16'd1;
          end else begin
            p_s  = p_r + 16'd1;
            oc_s = oc_r;
          end
          state_s = RUN;
          rd_en_s = 1'b1;
          first_s = 1'b1;
          ic_s    = 16'd1;
          paddr_s = w_addr(oc_s, 16'd0);
          raddr_s = x_addr(16'd0, p_s);
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
      ic_r    <= '0;
      p_r     <= '0;
      oc_r    <= '0;
      dcnt_r  <= '0;
      rd_en_r <= 1'b0;
      first_r <= 1'b0;
      wen_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      paddr_r <= '0;
      raddr_r <= '0;
      waddr_r <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_s;
      ic_r    <= ic_s;
      p_r     <= p_s;
      oc_r    <= oc_s;
      dcnt_r  <= dcnt_s;
      rd_en_r <= rd_en_s;
      first_r <= first_s;
      wen_r   <= wen_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      paddr_r <= paddr_s;
      raddr_r <= raddr_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
    end
  end

  // Read-valid and first-term flags delayed to line up with returning data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_r  <= '0;
      frst_r <= '0;
    end else begin
      vld_r  <= MEM_LAT'({vld_r, rd_en_r});
      frst_r <= MEM_LAT'({frst_r, first_r});
    end
  end

  assign pbank_addr  = paddr_r;
  assign pbank_en    = rd_en_r;
  assign fbank_raddr = raddr_r;
  assign fbank_ren   = rd_en_r;
  assign fbank_waddr = waddr_r;
  assign fdata_w     = wdata_r;
  assign fbank_wen   = wen_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule
